// File: rtl/tp_link_tx.sv
// Clocked transmitter for a dual-rail two-phase link: one rail transition per data bit, next token
// only after the receiver's ack toggle. Optional ack watchdog built with TP_LINK_TX_TIMEOUT_EN.

module tp_link_tx_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       d,
  output logic [1:0] rails
);
  // Two-phase encoding: a transition on the 1-rail carries a one, on the 0-rail a zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rails <= 2'b00;
    else if (load) rails <= rails ^ (d ? 2'b10 : 2'b01);
  end
endmodule

module tp_link_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] link,
  input  logic               ack,
  output logic               busy,
  output logic [15:0]        tx_count,
  output logic               proto_err,
  output logic               timeout
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_chk
    $error("tp_link_tx: SYNC_STAGES must be 2..4 and TIMEOUT_CYC 1..65535");
  end

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   ack_phase;
  logic                   ack_edge;
  logic                   accept;

  // Raw ack is only ever seen by the first synchroniser flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign ack_edge = ack_s != ack_phase;
  assign accept   = in_ready & in_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    tp_link_tx_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .d     (in_data[i]),
      .rails (link[2*i+1:2*i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      tx_count  <= 16'd0;
      proto_err <= 1'b0;
      ack_phase <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A stray ack is absorbed and flagged; it does not block a same-cycle accept.
          if (ack_edge) begin
            ack_phase <= ack_s;
            proto_err <= 1'b1;
          end
          if (in_valid) begin
            state    <= S_WAIT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (ack_edge) begin
            ack_phase <= ack_s;
            tx_count  <= tx_count + 16'd1;
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef TP_LINK_TX_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);
  logic [15:0] wait_cnt;
  logic        timeout_q;

  // Watchdog only reports; the FSM keeps waiting for the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      wait_cnt <= 16'd0;
    end else if (busy) begin
      if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
      if (wait_cnt + 16'd1 == TO_LIMIT) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tp_link_tx.sv
// Directed + random bench for tp_link_tx; the bench plays the receiver and decodes link deltas
// against a queue of sent words.

module tb_tp_link_tx;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int TO   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] link;
  logic           ack;
  logic           busy;
  logic [15:0]    tx_count;
  logic           proto_err;
  logic           timeout;

  int             n_chk  = 0;
  int             n_fail = 0;
  logic [W-1:0]   sb_q[$];
  logic [2*W-1:0] prev_link;
  logic [15:0]    exp_cnt;

  tp_link_tx #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .link(link), .ack(ack), .busy(busy), .tx_count(tx_count), .proto_err(proto_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode the rail delta since the last token and compare it with the oldest queued word.
  task automatic check_link();
    logic [2*W-1:0] delta;
    logic [W-1:0]   dec;
    logic [W-1:0]   exp;
    int             bad;
    delta = link ^ prev_link;
    dec   = '0;
    bad   = 0;
    chk("sb_size", 64'(sb_q.size()), 64'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    for (int i = 0; i < W; i++) begin
      if (delta[2*i+:2] == 2'b10)      dec[i] = 1'b1;
      else if (delta[2*i+:2] == 2'b01) dec[i] = 1'b0;
      else                             bad++;
    end
    chk("decode", 64'(dec), 64'(exp));
    chk("toggles", 64'($countones(delta)), 64'(W));
    chk("pair_ok", 64'(bad), 64'd0);
    chk("busy_wait", 64'(busy), 64'd1);
    prev_link = link;
  endtask

  task automatic send(input logic [W-1:0] d, input bit hold);
    int k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("ready_wait", 64'(in_ready), 64'd1);
    in_data  = d;
    in_valid = 1'b1;
    sb_q.push_back(d);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check_link();
  endtask

  task automatic do_ack(input bit exact);
    int k = 0;
    ack = ~ack;
    if (exact) begin
      repeat (SYNC) @(negedge clk);
      chk("ready_early", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("ready_lat", 64'(in_ready), 64'd1);
    end else begin
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      chk("ack_wait", 64'(in_ready), 64'd1);
    end
    exp_cnt++;
    chk("tx_count", 64'(tx_count), 64'(exp_cnt));
    chk("busy_done", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; in_valid = 1'b0; in_data = '0;
    prev_link = '0; exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_link", 64'(link), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(tx_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single token 0xA5 with exact ack-to-ready latency
    send(8'hA5, 1'b0);
    chk("a5_link", 64'(link), 64'(16'b1001_1001_0110_0110));
    do_ack(1'b1);

    // Same word with in_valid held: rails return to zero, one accept per ack
    send(8'hA5, 1'b1);
    chk("a5_back", 64'(link), 64'd0);
    repeat (5) @(negedge clk);
    chk("hold_link", 64'(link), 64'd0);
    chk("hold_busy", 64'(busy), 64'd1);
    do_ack(1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_nosecond", 64'(link), 64'd0);
    chk("hold_idle", 64'(busy), 64'd0);

    // Stray ack while idle
    ack = ~ack;
    repeat (SYNC + 1) @(negedge clk);
    chk("perr_set", 64'(proto_err), 64'd1);
    chk("perr_cnt", 64'(tx_count), 64'(exp_cnt));
    send(8'h00, 1'b0);
    chk("zero_link", 64'(link), 64'(16'h5555));
    do_ack(1'b1);
    chk("perr_sticky", 64'(proto_err), 64'd1);

    // Withheld ack
    send(8'h3C, 1'b0);
`ifdef TP_LINK_TX_TIMEOUT_EN
    repeat (TO - 1) @(negedge clk);
    chk("to_early", 64'(timeout), 64'd0);
    @(negedge clk);
    chk("to_set", 64'(timeout), 64'd1);
    do_ack(1'b1);
    chk("to_sticky", 64'(timeout), 64'd1);
`else
    repeat (TO + 4) @(negedge clk);
    chk("to_off", 64'(timeout), 64'd0);
    chk("to_busy", 64'(busy), 64'd1);
    do_ack(1'b1);
    chk("to_off_done", 64'(timeout), 64'd0);
`endif

    // Random tokens with variable receiver delay
    for (int t = 0; t < 200; t++) begin
      send(W'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_ack(1'b0);
    end

    // Reset in the middle of a wait
    send(8'hF0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_link", 64'(link), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_cnt", 64'(tx_count), 64'd0);
    chk("mrst_perr", 64'(proto_err), 64'd0);
    chk("mrst_to", 64'(timeout), 64'd0);
    ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prev_link = '0;
    exp_cnt   = 16'd0;
    sb_q.delete();
    @(negedge clk);
    send(8'h81, 1'b0);
    do_ack(1'b1);
    chk("mrst_perr_after", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
